// File: rtl/ip4_rtl_pkg.sv
// Shared ip4 AXI widths and write-arbiter types.
// Imported by the arbiter top and its round-robin core.
package ip4_rtl_pkg;

  localparam int WID_AXI_ID     = 4;
  localparam int WID_AXI_ADDR   = 32;
  localparam int WID_AXI_DATA   = 128;
  localparam int BYTES_AXI_DATA = WID_AXI_DATA / 8;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W
  } ip4_wr_arb_st_e;

  typedef struct packed {
    logic [WID_AXI_ADDR-1:0] addr;
    logic [3:0]              len;
    logic [2:0]              size;
  } ip4_aw_req_s;

endpackage

// File: rtl/ip4_rr_arb.sv
// Combinational round-robin arbiter; search starts one past ptr.
// The pointer itself lives in the parent.
module ip4_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          hit;
  logic [IW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    ci  = '0;
    for (int i = 1; i <= N; i++) begin
      ci = IW'((int'(ptr) + i) % N);
      if (en && !hit && req[ci]) begin
        hit     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/ip4_axi_wr_arb.sv
// Burst-granular round-robin share of the ip4 AXI AW/W master port.
// One burst in flight; W beats follow the AW winner until generated wlast.
module ip4_axi_wr_arb
  import ip4_rtl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_awvalid,
  output logic [NUM_REQ-1:0]                req_awready,
  input  logic [NUM_REQ*WID_AXI_ADDR-1:0]   req_awaddr,
  input  logic [NUM_REQ*4-1:0]              req_awlen,
  input  logic [NUM_REQ*3-1:0]              req_awsize,
  input  logic [NUM_REQ-1:0]                req_wvalid,
  output logic [NUM_REQ-1:0]                req_wready,
  input  logic [NUM_REQ*WID_AXI_DATA-1:0]   req_wdata,
  input  logic [NUM_REQ*BYTES_AXI_DATA-1:0] req_wstrb,
  input  logic [NUM_REQ-1:0]                req_wlast,
  output logic [WID_AXI_ID-1:0]             awid,
  output logic [WID_AXI_ADDR-1:0]           awaddr,
  output logic [3:0]                        awlen,
  output logic [2:0]                        awsize,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [WID_AXI_ID-1:0]             wid,
  output logic [WID_AXI_DATA-1:0]           wdata,
  output logic [BYTES_AXI_DATA-1:0]         wstrb,
  output logic                              wlast,
  output logic                              wvalid,
  input  logic                              wready,
  output logic                              busy,
  output logic                              err_len
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ip4_wr_arb_st_e     st, st_nxt;
  logic [IW-1:0]      ptr, gidx, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_en;
  ip4_aw_req_s        aw_q, aw_d;
  logic [3:0]         beat_cnt;
  logic               whs;

  ip4_rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_awvalid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    aw_d.addr = req_awaddr[arb_idx*WID_AXI_ADDR +: WID_AXI_ADDR];
    aw_d.len  = req_awlen[arb_idx*4 +: 4];
    aw_d.size = req_awsize[arb_idx*3 +: 3];
  end

  always_comb begin
    st_nxt      = st;
    arb_en      = 1'b0;
    req_awready = '0;
    req_wready  = '0;
    wvalid      = 1'b0;
    wlast       = 1'b0;
    wid         = '0;
    wdata       = '0;
    wstrb       = '0;
    unique case (st)
      IDLE: begin
        arb_en      = 1'b1;
        req_awready = arb_gnt;
        if (|arb_gnt) st_nxt = AW;
      end
      AW: begin
        if (awready) st_nxt = W;
      end
      W: begin
        wvalid           = req_wvalid[gidx];
        req_wready[gidx] = wready;
        wlast            = (beat_cnt == aw_q.len);
        wid              = WID_AXI_ID'(gidx);
        wdata = req_wdata[gidx*WID_AXI_DATA +: WID_AXI_DATA];
        wstrb = req_wstrb[gidx*BYTES_AXI_DATA +: BYTES_AXI_DATA];
        if (req_wvalid[gidx] && wready && wlast) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign whs     = (st == W) && req_wvalid[gidx] && wready;
  assign awvalid = (st == AW);
  assign busy    = (st != IDLE);
  assign awid    = WID_AXI_ID'(gidx);
  assign awaddr  = aw_q.addr;
  assign awlen   = aw_q.len;
  assign awsize  = aw_q.size;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      ptr      <= IW'(NUM_REQ - 1);
      gidx     <= '0;
      aw_q     <= '0;
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == IDLE && |arb_gnt) begin
        gidx <= arb_idx;
        aw_q <= aw_d;
      end
      // Burst length is owned here; requester wlast only flags errors
      if (whs) begin
        if (req_wlast[gidx] != wlast) err_len <= 1'b1;
        if (wlast) begin
          beat_cnt <= '0;
          ptr      <= gidx;
        end else begin
          beat_cnt <= beat_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ip4_axi_wr_arb.sv
// Bench for ip4_axi_wr_arb: cycle model compared every negedge,
// plus directed scenarios with literal expectations.
module tb_ip4_axi_wr_arb;
  import ip4_rtl_pkg::*;

  localparam int N  = 4;
  localparam int DW = WID_AXI_DATA;
  localparam int SW = BYTES_AXI_DATA;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]    req_awvalid, req_awready;
  logic [N*32-1:0] req_awaddr;
  logic [N*4-1:0]  req_awlen;
  logic [N*3-1:0]  req_awsize;
  logic [N-1:0]    req_wvalid, req_wready, req_wlast;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [3:0]      awid, wid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;
  logic            wlast, wvalid, wready, busy, err_len;

  ip4_axi_wr_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_awvalid(req_awvalid), .req_awready(req_awready),
    .req_awaddr(req_awaddr), .req_awlen(req_awlen),
    .req_awsize(req_awsize), .req_wvalid(req_wvalid),
    .req_wready(req_wready), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_wlast(req_wlast),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester stimulus state
  logic [31:0] rq_addr[N];
  int          rq_len[N];
  int          rq_cnt[N];
  logic [N-1:0] bad_wlast;

  always_comb begin
    req_awaddr = '0;
    req_awlen  = '0;
    req_awsize = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    req_wlast  = '0;
    for (int i = 0; i < N; i++) begin
      req_awaddr[i*32 +: 32] = rq_addr[i];
      req_awlen[i*4 +: 4]    = 4'(rq_len[i]);
      req_awsize[i*3 +: 3]   = 3'd4;
      req_wdata[i*DW +: DW]  = {32'hC0DE0000 | 32'(i), 64'h0, 16'h0,
                                16'(rq_cnt[i])};
      req_wstrb[i*SW +: SW]  = 16'hFFFF >> i;
      req_wlast[i] = (rq_cnt[i] == rq_len[i]) ^ bad_wlast[i];
    end
  end

  // Requester beat counters follow accepted W beats
  always @(posedge clk) begin
    logic [N-1:0] hs;
    cyc++;
    hs = req_wready & req_wvalid;
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) rq_cnt[i] = 0;
      else if (hs[i]) rq_cnt[i] = (rq_cnt[i] == rq_len[i]) ? 0 : rq_cnt[i] + 1;
    end
  end

  // Behavioural model: 0 idle, 1 address phase, 2 data phase
  int          m_st, m_g, m_ptr, m_cnt, m_awid, m_len, m_size;
  bit          m_err;
  logic [31:0] m_addr;

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (req_awvalid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int p;
    bit lst;
    if (!rst_n) begin
      m_st = 0; m_g = 0; m_ptr = N - 1; m_cnt = 0; m_awid = 0;
      m_len = 0; m_size = 0; m_err = 0; m_addr = 0;
    end else if (m_st == 0) begin
      p = rr_pick();
      if (p >= 0) begin
        m_g = p; m_awid = p; m_addr = rq_addr[p];
        m_len = rq_len[p]; m_size = 4; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (awready) m_st = 2;
    end else if (req_wvalid[m_g] && wready) begin
      lst = (m_cnt == m_len);
      if (req_wlast[m_g] != lst) m_err = 1;
      if (lst) begin
        m_st = 0; m_ptr = m_g; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  int aw_log[$];
  int aw_cyc[$];
  int w_beat[$];
  int w_req[$];
  int w_id[$];
  bit w_last[$];

  always @(negedge clk) begin
    int p;
    logic [N-1:0] e_awr, e_wr;
    p = (m_st == 0) ? rr_pick() : -1;
    e_awr = (p >= 0) ? (4'd1 << p) : 4'd0;
    e_wr  = (m_st == 2 && wready) ? (4'd1 << m_g) : 4'd0;
    chk("req_awready", req_awready, e_awr);
    chk("req_wready", req_wready, e_wr);
    chk("awvalid", awvalid, m_st == 1);
    chk("awid", awid, m_awid);
    chk("awaddr", awaddr, m_addr);
    chk("awlen", awlen, m_len);
    chk("awsize", awsize, m_size);
    chk("busy", busy, m_st != 0);
    chk("err_len", err_len, m_err);
    chk("wvalid", wvalid, m_st == 2 && req_wvalid[m_g]);
    chk("wlast", wlast, m_st == 2 && m_cnt == m_len);
    chk("wid", wid, (m_st == 2) ? m_g : 0);
    chk("wdata", wdata, (m_st == 2) ? req_wdata[m_g*DW +: DW] : '0);
    chk("wstrb", wstrb, (m_st == 2) ? req_wstrb[m_g*SW +: SW] : '0);
    if (awvalid && awready) begin
      aw_log.push_back(int'(awid));
      aw_cyc.push_back(cyc);
    end
    if (wvalid && wready) begin
      w_beat.push_back(int'(wdata[15:0]));
      w_req.push_back(int'(wdata[103:96]));
      w_id.push_back(int'(wid));
      w_last.push_back(wlast);
    end
  end

  task automatic clr_logs();
    aw_log.delete(); aw_cyc.delete();
    w_beat.delete(); w_req.delete(); w_id.delete(); w_last.delete();
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string nm);
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, busy, 1'b0);
    align();
  endtask

  task automatic issue(int i, string nm);
    int k = 0;
    req_awvalid[i] = 1'b1;
    @(negedge clk);
    while (!req_awready[i] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(nm, req_awready[i], 1'b1);
    align();
    req_awvalid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int stall;
    req_awvalid = '0;
    req_wvalid = '0;
    bad_wlast = '0;
    awready = 1'b1;
    wready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rq_addr[i] = 32'h100 * (i + 1);
      rq_len[i] = 0;
    end
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_err", err_len, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All requesters persistent, single-beat bursts
    clr_logs();
    req_wvalid = 4'hF;
    req_awvalid = 4'hF;
    k = 0;
    while (aw_log.size() < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rot_count", aw_log.size() >= 5, 1'b1);
    align();
    req_awvalid = '0;
    wait_idle("rot_idle");
    if (aw_log.size() >= 5) begin
      chk("rot_g0", aw_log[0], 0);
      chk("rot_g1", aw_log[1], 1);
      chk("rot_g2", aw_log[2], 2);
      chk("rot_g3", aw_log[3], 3);
      chk("rot_g4", aw_log[4], 0);
      chk("rot_gap", aw_cyc[1] - aw_cyc[0], 3);
    end
    req_wvalid = '0;

    // Single requester 1, four beats
    clr_logs();
    rq_addr[1] = 32'h1000;
    rq_len[1] = 3;
    req_wvalid[1] = 1'b1;
    req_awvalid[1] = 1'b1;
    @(negedge clk);
    chk("t1_awready", req_awready, 4'b0010);
    align();
    req_awvalid[1] = 1'b0;
    @(negedge clk);
    chk("t1_awvalid", awvalid, 1'b1);
    chk("t1_awid", awid, 4'd1);
    chk("t1_awaddr", awaddr, 32'h1000);
    align();
    wait_idle("t1_idle");
    chk("t1_beats", w_beat.size(), 4);
    if (w_beat.size() == 4) begin
      chk("t1_last", {w_last[0], w_last[1], w_last[2], w_last[3]}, 4'b0001);
      chk("t1_wid", w_id[3], 1);
      chk("t1_beat3", w_beat[3], 3);
    end
    chk("t1_err", err_len, 1'b0);
    req_wvalid = '0;

    // AW stall: awready low five cycles
    clr_logs();
    awready = 1'b0;
    rq_addr[2] = 32'h2000;
    rq_len[2] = 0;
    req_wvalid[2] = 1'b1;
    issue(2, "t3_grant");
    stall = 0;
    repeat (5) begin
      @(negedge clk);
      if (awvalid && awaddr == 32'h2000 && awid == 4'd2 && req_awready == 0)
        stall++;
    end
    chk("t3_stall", stall, 5);
    align();
    awready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_aw", aw_log.size(), 1);

    // wready toggling during an eight-beat burst
    clr_logs();
    rq_len[2] = 7;
    issue(2, "t4_grant");
    k = 0;
    while (w_beat.size() < 8 && k < 100) begin
      align();
      wready = ~wready;
      k++;
    end
    wready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_beats", w_beat.size(), 8);
    for (int i = 0; i < w_beat.size() && i < 8; i++) begin
      chk("t4_order", w_beat[i], i);
      chk("t4_req", w_req[i], 2);
    end
    req_wvalid = '0;

    // Early requester wlast
    clr_logs();
    rq_len[0] = 1;
    bad_wlast[0] = 1'b1;
    req_wvalid[0] = 1'b1;
    issue(0, "t5_grant");
    wait_idle("t5_idle");
    chk("t5_err", err_len, 1'b1);
    chk("t5_beats", w_last.size(), 2);
    if (w_last.size() == 2) chk("t5_last", {w_last[0], w_last[1]}, 2'b01);
    bad_wlast = '0;
    req_wvalid = '0;
    repeat (3) align();
    chk("t5_sticky", err_len, 1'b1);

    // Reset in the middle of a four-beat burst
    clr_logs();
    rq_len[3] = 3;
    req_wvalid[3] = 1'b1;
    issue(3, "t6_grant");
    k = 0;
    while (w_beat.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_wvalid", wvalid, 1'b0);
    chk("t6_wready", req_wready, 4'b0000);
    chk("t6_err", err_len, 1'b0);
    repeat (2) align();
    rst_n = 1'b1;
    rq_len[0] = 0;
    req_wvalid[0] = 1'b1;
    req_awvalid[0] = 1'b1;
    req_awvalid[3] = 1'b1;
    @(negedge clk);
    chk("t6_regrant", req_awready, 4'b0001);
    align();
    req_awvalid = '0;
    wait_idle("t6_idle");
    chk("t6_err_after", err_len, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ip4_axi_wr_arb.md
Name: ip4_axi_wr_arb

Overview:
- Shares the single ip4 AXI write master port (AW + W channels) between NUM_REQ internal write requesters.
- Round-robin arbitration at burst granularity.
- Exactly one burst outstanding at a time. Once an AW is granted, the winner's W beats are routed until the burst completes.
- Sits between the ip4 internal engines and the ip4_axi_if master modport.

Parameters:
- NUM_REQ, 4, number of requesters; must satisfy NUM_REQ <= 2**WID_AXI_ID.
- WID_AXI_ID, 4, AXI ID width (ip4_rtl_pkg).
- WID_AXI_ADDR, 32, AXI address width (ip4_rtl_pkg).
- WID_AXI_DATA, 128, AXI data width (ip4_rtl_pkg).
- BYTES_AXI_DATA, WID_AXI_DATA/8, strobe width (ip4_rtl_pkg).

Ports:
- clk  in  1  single clock; AXI side runs on the same clock (aclk == clk).
- rst_n  in  1  asynchronous active-low reset.
- req_awvalid  in  NUM_REQ  per-requester AW valid.
- req_awready  out  NUM_REQ  per-requester AW accept (one-hot or zero).
- req_awaddr  in  NUM_REQ*WID_AXI_ADDR  packed addresses; requester i at slice i.
- req_awlen  in  NUM_REQ*4  packed burst length minus 1.
- req_awsize  in  NUM_REQ*3  packed beat size.
- req_wvalid  in  NUM_REQ  per-requester W valid.
- req_wready  out  NUM_REQ  per-requester W ready.
- req_wdata  in  NUM_REQ*WID_AXI_DATA  packed write data.
- req_wstrb  in  NUM_REQ*BYTES_AXI_DATA  packed strobes.
- req_wlast  in  NUM_REQ  requester last flag; checked only, not forwarded.
- awid, awaddr, awlen, awsize, awvalid  out  WID_AXI_ID/WID_AXI_ADDR/4/3/1  AXI AW channel to slave.
- awready  in  1  AXI AW ready.
- wid, wdata, wstrb, wlast, wvalid  out  WID_AXI_ID/WID_AXI_DATA/BYTES_AXI_DATA/1/1  AXI W channel.
- wready  in  1  AXI W ready.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_len  out  1  sticky flag: req_wlast disagreed with the arbiter-generated wlast; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: awvalid=0, wvalid=0, wlast=0, busy=0, err_len=0, req_awready=0, req_wready=0. awid/awaddr/awlen/awsize/wid=0. rr pointer=NUM_REQ-1, so req0 has top priority. Beat counter=0. Reset mid-burst abandons the burst; nothing is replayed.
- FSM states: IDLE, AW, W.
- IDLE:
  - Round-robin grant among req_awvalid, starting at (ptr+1) mod NUM_REQ.
  - req_awready is driven combinationally: req_awready[g]=1 for the winner g only, in that same cycle.
  - The winner's addr/len/size are captured into registers. awid=g zero-extended; the grant index g is registered.
  - Next state AW. No request pending -> stay IDLE, all readies 0.
- AW:
  - awvalid=1; fields stay stable until awready.
  - awvalid&awready -> W next cycle; awvalid drops.
  - Minimum latency from req_awvalid (IDLE) to awvalid is 1 cycle.
- W:
  - Combinational routing: wvalid=req_wvalid[g], req_wready[g]=wready, wdata/wstrb from slice g, wid=g.
  - req_wready=0 for all other requesters.
  - wlast = (beat_cnt == awlen_reg). The arbiter generates wlast; the requester does not.
  - On each wvalid&wready, beat_cnt increments (4-bit, 0..15, no wrap needed).
  - On a handshake where req_wlast[g] != wlast: set err_len. The burst still ends on the generated last.
  - Handshake with wlast=1 -> IDLE, ptr=g, beat_cnt=0.
  - New arbitration happens in the IDLE cycle, so there is a 1-cycle bubble between bursts.
- req_wready is 0 outside W. Requesters must not depend on W-before-AW acceptance.
- AW requests from other requesters during AW/W are ignored; they hold valid per AXI rules.
- Same-cycle assertion by all requesters: grant order is strictly rotating, for example 0,1,2,3,0…
- awlen=0: a single beat, wlast=1 on the first beat.

Decomposition:
- ip4_rtl_pkg holds:
  - WID_AXI_ID/ADDR/DATA and BYTES_AXI_DATA;
  - typedef enum ip4_wr_arb_st_e {IDLE,AW,W};
  - typedef struct ip4_aw_req_s {addr,len,size}.
- Sub-module ip4_rr_arb: NUM_REQ-wide round-robin arbiter. Inputs are req vector, ptr and en. Output is the one-hot grant plus a binary index. It is combinational; the pointer is held in the parent.

Test Plan:
- Single requester, req1: awaddr=0x1000, awlen=3, 4 beats, wready=1 -> awid=1 and awvalid 1 cycle after req_awvalid. 4 W beats with wid=1 and wlast only on beat 4. err_len=0; busy falls after the last beat.
- All 4 requesters request awlen=0 simultaneously and persistently -> AW grant order 0,1,2,3,0. Each burst is 1 beat, with a 1-cycle IDLE bubble between bursts.
- awready held low 5 cycles -> awaddr/awlen/awid stable and awvalid high throughout. All req_awready=0 during the stall.
- wready toggling 1,0,1,0 during an awlen=7 burst from req2 -> exactly 8 handshakes forwarded in order. req_wready[2] mirrors wready; other req_wready stay 0.
- req0 awlen=1 but asserts req_wlast on beat 1 -> err_len=1 (sticky). Burst completes after beat 2 with wlast=1; FSM returns to IDLE.
- rst_n pulsed low mid-W (beat 2 of 4) -> outputs reset immediately (async). After release, the next grant goes to req0 and err_len=0.
